// File: rtl/msk_diff_mod.sv
`default_nettype none
// ============================================================================
// Module      : msk_diff_mod
// Description : Continuous-phase MSK baseband modulator. Takes one hard bit
//               per symbol over a valid/ready handshake and emits SPS complex
//               samples per symbol on sample_en_i. A '1' advances the carrier
//               phase by +pi/2 over the symbol and a '0' by -pi/2, so a
//               differential slicer on symbol-boundary samples recovers the
//               bit. Each burst ends with one constant-phase TAIL symbol.
// Ports       : clk, reset (async, active high)
//               sample_en_i                       - produce one sample
//               data_i / data_valid_i / data_ready_o - bit input handshake
//               i_o / q_o                         - signed I/Q, IW bits
//               sample_valid_o                    - I/Q updated this cycle
//               sym_strobe_o                      - first sample of a symbol
//               busy_o                            - burst in progress
// Options     : MSK_DIFF_MOD_PREAMBLE_EN - prefix each burst with PRE_LEN
//               alternating 1,0,... symbols.
// Revision    : 1.0 - initial release
// ============================================================================
module msk_diff_mod #(
    parameter int IW      = 18,
    parameter int SPS     = 8,
    parameter int PW      = 16,
    parameter int LW      = 8,
    parameter int AMP     = 2**(IW-1) - 1,
    parameter int PRE_LEN = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_en_i,
    input  logic          data_i,
    input  logic          data_valid_i,
    output logic          data_ready_o,
    output logic [IW-1:0] i_o,
    output logic [IW-1:0] q_o,
    output logic          sample_valid_o,
    output logic          sym_strobe_o,
    output logic          busy_o
);

`ifdef MSK_DIFF_MOD_PREAMBLE_EN
    localparam bit c_PRE_EN = 1'b1;
`else
    localparam bit c_PRE_EN = 1'b0;
`endif

    localparam int            c_CNT_W   = $clog2(SPS);
    localparam int            c_PRE_W   = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    localparam int            c_LUT_N   = 2**LW;
    // A quarter turn spread exactly over SPS samples.
    localparam logic [PW-1:0] c_INC     = PW'((2**(PW-2)) / SPS);
    localparam logic [PW-1:0] c_INC_NEG = ~c_INC + 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    // Quarter-wave sine/cosine by Taylor series, unfolded to the full circle
    // by quadrant so that the cardinal points come out exact.
    function automatic logic [IW-1:0] lut_entry(input int a, input logic want_q);
        real x, t, c, s, v;
        int  quad, r, n;
        quad = (a >> (LW - 2)) & 3;
        r    = a & ((1 << (LW - 2)) - 1);
        x    = 6.283185307179586 * r / c_LUT_N;
        s    = 0.0;
        t    = x;
        for (n = 1; n < 22; n += 2) begin
            s = s + t;
            t = -t * x * x / ((n + 1) * (n + 2));
        end
        c = 0.0;
        t = 1.0;
        for (n = 0; n < 22; n += 2) begin
            c = c + t;
            t = -t * x * x / ((n + 1) * (n + 2));
        end
        case (quad)
            0:       v = want_q ?  s :  c;
            1:       v = want_q ?  c : -s;
            2:       v = want_q ? -s : -c;
            default: v = want_q ? -c :  s;
        endcase
        v = v * AMP;
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return IW'(r);
    endfunction

    logic [IW-1:0] w_lut_i [c_LUT_N];
    logic [IW-1:0] w_lut_q [c_LUT_N];

    for (genvar a = 0; a < c_LUT_N; a++) begin : g_lut
        assign w_lut_i[a] = lut_entry(a, 1'b0);
        assign w_lut_q[a] = lut_entry(a, 1'b1);
    end

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_ph, w_ph_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [c_PRE_W-1:0]  r_pre_cnt, w_pre_cnt_nxt;
    logic                r_cur_bit, w_cur_bit_nxt;
    logic                r_buf, w_buf_nxt;
    logic                r_buf_full, w_buf_full_nxt;
    logic [IW-1:0]       w_i_nxt, w_q_nxt;
    logic                w_valid_nxt, w_strobe_nxt;
    logic                w_bound, w_fire, w_dir, w_move;
    logic [LW-1:0]       w_addr;

    assign w_addr       = r_ph[PW-1 -: LW];
    assign data_ready_o = !r_buf_full;
    assign busy_o       = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt    = r_state;
        w_ph_nxt       = r_ph;
        w_cnt_nxt      = r_cnt;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_cur_bit_nxt  = r_cur_bit;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_i_nxt        = i_o;
        w_q_nxt        = q_o;
        w_valid_nxt    = 1'b0;
        w_strobe_nxt   = 1'b0;
        w_dir          = r_cur_bit;
        w_move         = 1'b0;
        w_bound        = (r_cnt == c_CNT_W'(SPS - 1));
        // In IDLE with nothing buffered the strobe is ignored entirely.
        w_fire         = sample_en_i && ((r_state != S_IDLE) || r_buf_full);

        // Accept and load are mutually exclusive: accept needs an empty
        // buffer, load needs a full one.
        if (data_valid_i && !r_buf_full) begin
            w_buf_nxt      = data_i;
            w_buf_full_nxt = 1'b1;
        end

        if (w_fire) begin
            w_valid_nxt  = 1'b1;
            w_strobe_nxt = (r_cnt == '0);
            w_i_nxt      = w_lut_i[w_addr];
            w_q_nxt      = w_lut_q[w_addr];
            w_cnt_nxt    = w_bound ? '0 : r_cnt + 1'b1;
            w_move       = (r_state != S_TAIL);

            case (r_state)
                S_IDLE: begin
                    if (c_PRE_EN) begin
                        w_state_nxt   = S_PRE;
                        w_cur_bit_nxt = 1'b1;
                        w_pre_cnt_nxt = '0;
                    end else begin
                        w_state_nxt    = S_DATA;
                        w_cur_bit_nxt  = r_buf;
                        w_buf_full_nxt = 1'b0;
                    end
                    // This sample opens the new symbol, so it steers by the
                    // freshly loaded bit rather than the stale one.
                    w_dir = w_cur_bit_nxt;
                end
                S_PRE: begin
                    if (w_bound) begin
                        if (r_pre_cnt == c_PRE_W'(PRE_LEN - 1)) begin
                            if (r_buf_full) begin
                                w_state_nxt    = S_DATA;
                                w_cur_bit_nxt  = r_buf;
                                w_buf_full_nxt = 1'b0;
                            end else begin
                                w_state_nxt = S_TAIL;
                            end
                        end else begin
                            w_pre_cnt_nxt = r_pre_cnt + 1'b1;
                            w_cur_bit_nxt = ~r_cur_bit;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bound) begin
                        if (r_buf_full) begin
                            w_cur_bit_nxt  = r_buf;
                            w_buf_full_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (w_bound) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase

            // Sample is taken at the current phase, then the phase advances.
            w_ph_nxt = r_ph + (w_move ? (w_dir ? c_INC : c_INC_NEG) : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ph           <= '0;
            r_cnt          <= '0;
            r_pre_cnt      <= '0;
            r_cur_bit      <= 1'b0;
            r_buf          <= 1'b0;
            r_buf_full     <= 1'b0;
            i_o            <= '0;
            q_o            <= '0;
            sample_valid_o <= 1'b0;
            sym_strobe_o   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ph           <= w_ph_nxt;
            r_cnt          <= w_cnt_nxt;
            r_pre_cnt      <= w_pre_cnt_nxt;
            r_cur_bit      <= w_cur_bit_nxt;
            r_buf          <= w_buf_nxt;
            r_buf_full     <= w_buf_full_nxt;
            i_o            <= w_i_nxt;
            q_o            <= w_q_nxt;
            sample_valid_o <= w_valid_nxt;
            sym_strobe_o   <= w_strobe_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/msk_diff_mod.md
# msk_diff_mod

Continuous-phase MSK baseband modulator: the transmit-side counterpart of the differential slicer/decoder. It accepts one hard bit per symbol over a valid/ready handshake and emits `SPS` complex samples per symbol on a sample-enable strobe. The phase moves linearly by +π/2 over the symbol for bit 1 and by −π/2 for bit 0. The receiver decision `sign(Im{S_k·conj(S_k-1)})` on symbol-boundary samples therefore returns the transmitted bit. It feeds the DAC/upconversion path and serves as the stimulus source for modem loopback benches.

## Interface
- `IW`, 18: I/Q output width, signed.
- `SPS`, 8: samples per symbol; power of two, 2..64.
- `PW`, 16: phase accumulator width; `SPS` ≤ 2^(PW-2).
- `LW`, 8: LUT address bits; LW ≥ log2(4·SPS).
- `AMP`, 2^(IW-1)-1: output amplitude.
- `PRE_LEN`, 16: preamble length in symbols; used only with the macro.
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_en_i`  in  1: one output sample is produced per cycle with this high.
- `data_i`  in  1: bit to transmit.
- `data_valid_i`  in  1: `data_i` valid.
- `data_ready_o`  out  1: equals `!buf_full`; a transfer occurs on `data_valid_i && data_ready_o`.
- `i_o`, `q_o`  out  IW each: signed I/Q sample.
- `sample_valid_o`  out  1: `i_o`/`q_o` updated this cycle.
- `sym_strobe_o`  out  1: qualifies the first sample (cnt==0) of each symbol.
- `busy_o`  out  1: state ≠ IDLE.

## Operation
- **Bit buffer:** a 1-entry bit buffer (`buf`, `buf_full`).
  - Accepting a bit sets `buf_full`. A symbol-boundary load clears it.
  - Accept and load cannot coincide, because `data_ready_o` is low whenever `buf_full` is set.
- **Phase accumulator:** `ph[PW-1:0]` increments by `±INC` once per sample, where `INC = 2^(PW-2)/SPS` (exact). Wrap is modulo 2^PW.
  - Phase is never cleared between bursts. It is continuous across bursts and only `reset` zeroes it.
- **LUT:** address is `ph[PW-1 -: LW]`.
  - `i = round(AMP·cos(2π·a/2^LW))`, `q = round(AMP·sin(…))`.
  - The table is built at elaboration.
- **Symbol counter:** `cnt` runs 0..SPS-1 and advances on `sample_en_i` in non-IDLE states.
  - A symbol boundary is a `sample_en_i` cycle with `cnt == SPS-1`.
- **Sample production:** each sample is taken at the current `ph`, then `ph` is updated. The cnt==0 sample therefore sits at a multiple of π/2 relative to the burst start.
- **FSM:**
  - **IDLE:** `sample_en_i` with `buf_full` loads `cur_bit ← buf` and goes to DATA, emitting sample cnt=0. With the macro enabled it goes to PRE instead. With `buf_full` low, `sample_en_i` is ignored and outputs hold.
  - **PRE:** `cur_bit` alternates 1,0,1,0… for `PRE_LEN` symbols. The buffer is untouched. At the final boundary the FSM goes to DATA, loading `buf` if full, else goes to TAIL.
  - **DATA:** direction is +INC if `cur_bit`, else −INC. At each boundary it loads `buf` if full; if empty it goes to TAIL.
  - **TAIL:** one symbol of SPS samples at constant phase (increment 0), giving the receiver its final reference. It then goes to IDLE. A bit arriving during TAIL starts a new burst from IDLE.
- **Receiver view of TAIL:** the receiver sees the TAIL symbol as imag=0 and decodes it as 1. Framing layers discard it.

## Timing
- **Output latency:** `i_o`, `q_o`, `sample_valid_o` and `sym_strobe_o` are registered and appear exactly 1 clk after the `sample_en_i` that produced them.
- **Handshake:** `data_ready_o` is combinational from `buf_full` and has no path from `sample_en_i`.
- **Upstream deadline:** a bit must be accepted before the next boundary to avoid TAIL insertion.
- **Reset values:**
  - state IDLE, `ph=0`, `cnt=0`, `buf_full=0`.
  - `i_o=0`, `q_o=0`, `sample_valid_o=0`, `sym_strobe_o=0`, `busy_o=0`.
  - `data_ready_o=1`.
  - Handshake transfers are ignored while `reset` is high.
- **Reset mid-burst:** aborts immediately. Any buffered bit is lost.

## Configuration
- **`MSK_DIFF_MOD_PREAMBLE_EN` defined:** the PRE state is compiled in, and every burst starts with `PRE_LEN` alternating symbols.
- **Not defined:** PRE and `PRE_LEN` are unused, and IDLE goes directly to DATA.

## Test plan
- **Single bit:** SPS=8, `sample_en_i` every cycle, one bit 1 → 16 samples (8 DATA, 8 TAIL).
  - First sample I=AMP, Q=0.
  - TAIL samples I≈0, Q=AMP.
  - `busy_o` falls after the 16th.
- **All ones:** bits 1,1,1,1 → cnt==0 phases 0°, 90°, 180°, 270°, then TAIL at 0°. Bits 0,0 → 0°, 270°, then TAIL at 180°.
- **Loopback:** 1000 random bits with `sample_en_i` every 3rd clk. Samples qualified by `sym_strobe_o` feed the slicer/decoder → decoded stream equals input (first decision discarded). No TAIL occurs mid-burst.
- **Backpressure:** hold `data_valid_i` with a new bit each transfer → `data_ready_o` low from accept until the next boundary; no bit dropped or duplicated.
- **Reset mid-burst:** assert `reset` during symbol 3, cnt=5 → all outputs at reset values the same cycle; `ph=0`; next burst starts at I=AMP.
- **Preamble:** macro on, PRE_LEN=4, data 0 → cnt==0 phases 0°, 90°, 0°, 90°, 0°, then 270° (TAIL).
